load_unit_ctrl: RTL and testbench
=================================

Name: load_unit_ctrl

Overview:
Sequencer for RV32I loads between the decode stage and the data-memory port. It accepts one load at a time: kind from the load decoder, effective address and destination register. It checks alignment, issues one word-aligned memory read with a valid/ready handshake, and waits for the response, with a timeout. It then extracts and sign/zero-extends the byte/half/word and emits a one-cycle writeback or exception pulse. A flush input cancels an in-flight load without corrupting the memory protocol.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT, 255, max cycles in WAIT before access fault (must be >= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  load request present
req_ready  out  1  high iff state IDLE
req_kind  in  load_kind_t  lk_lb/lk_lh/lk_lw/lk_lbu/lk_lhu/lk_invalid
req_addr  in  XLEN  effective byte address
req_rd  in  5  destination register
flush  in  1  cancel in-flight load
mem_req_valid  out  1  read request
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  {addr[31:2],2'b00}
mem_resp_valid  in  1  read data valid
mem_resp_data  in  XLEN  aligned word read
wb_valid  out  1  one-cycle writeback pulse
wb_rd  out  5  destination register
wb_data  out  XLEN  extended load result
exc_valid  out  1  one-cycle exception pulse
exc_cause  out  4  2 illegal, 4 load misaligned, 5 load access fault
exc_addr  out  XLEN  faulting address (mtval)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state IDLE, timer 0, latched kind/addr/rd 0; wb_valid, exc_valid, mem_req_valid, busy 0; wb_data, wb_rd, exc_cause, exc_addr 0. req_ready reads 1 because the state is IDLE. Reset mid-operation abandons the load; no pulse follows.
- States: IDLE, REQ, WAIT, DRAIN. wb_valid, exc_valid and their payloads are registered. Each pulse lasts exactly one cycle; payloads hold until the next pulse.
- IDLE: on req_valid && !flush the request is accepted; flush in IDLE blocks acceptance. On acceptance:
  - lk_invalid: exc cause 2, exc_addr=req_addr next cycle; stay IDLE.
  - Misaligned (lh/lhu with addr[0]=1; lw with addr[1:0]!=0): exc cause 4, exc_addr=req_addr next cycle; stay IDLE; no memory request.
  - Otherwise: latch kind/addr/rd, go to REQ.
- REQ: mem_req_valid=1, mem_addr stable. On mem_req_ready, go to WAIT with timer=0. If flush is high and mem_req_ready is low, go to IDLE and drop the request. If flush is high and mem_req_ready is high, the handshake completes and the block goes to DRAIN. mem_resp_valid is ignored in REQ.
- WAIT: timer increments each cycle.
  - mem_resp_valid: extract, pulse wb next cycle, go to IDLE.
  - Else if timer==TIMEOUT-1: exc cause 5, exc_addr=latched addr, go to IDLE.
  - A response wins over a timeout in the same cycle.
  - flush: go to DRAIN, timer keeps running.
- DRAIN: waits for mem_resp_valid or timeout, then goes to IDLE with no pulse; req_ready=0 throughout.
- Extraction, with off=addr[1:0]:
  - lb/lbu: byte mem_resp_data[8*off+7:8*off].
  - lh/lhu: half at bits [16*addr[1]+15 : 16*addr[1]].
  - lw: full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Latency, with accept at edge T and zero memory wait: mem_req_valid high in the cycle after T. The response is sampled one edge after the request handshake. wb_valid is high in the cycle after that sample, so the minimum is 3 cycles from accept to wb_valid.
- Only one outstanding request. mem_resp_valid in IDLE is ignored.

Test Plan:
- lb addr 0x0000_1003, resp 0x80FF_1234 → mem_addr 0x0000_1000; wb_data 0xFFFF_FF80; wb_rd echoed; wb_valid 1 cycle; latency 3 with zero-wait memory.
- lh / lhu addr 0x2002, resp 0x8001_7FFF → wb_data 0xFFFF_8001 / 0x0000_8001; lbu addr 0x2001 → 0x0000_007F.
- lw addr 0x3001 → exc_valid, cause 4, exc_addr 0x3001, mem_req_valid never asserted; lk_invalid → cause 2.
- mem_req_ready held low 5 cycles → mem_req_valid/mem_addr stable, req_ready 0, busy 1; then normal wb.
- TIMEOUT=4, no resp → cause 5 after 4 WAIT cycles; a second run with resp on the 4th WAIT cycle → wb, no exception.
- flush in WAIT, resp 3 cycles later → no wb/exc, req_ready 0 until resp, then 1.
- flush in REQ with mem_req_ready low → IDLE next cycle.
- rst pulled low mid-WAIT → all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/load_unit_ctrl_pkg.sv
// Shared types for the load sequencer.
// load_kind_t: load flavour from the decoder; encodings above lk_invalid are also illegal.
package load_unit_ctrl_pkg;

    typedef enum logic [2:0] {
        lk_lb      = 3'd0,
        lk_lh      = 3'd1,
        lk_lw      = 3'd2,
        lk_lbu     = 3'd3,
        lk_lhu     = 3'd4,
        lk_invalid = 3'd5
    } load_kind_t;

endpackage

// File: rtl/load_unit_ctrl.sv
// RV32I load sequencer between decode and the data-memory read port.
// Accepts one load at a time, checks alignment, issues a word-aligned read,
// waits for the response (with timeout), extracts and extends the result and
// emits a one-cycle writeback or exception pulse. Flush cancels in flight
// without breaking the memory handshake.
// Ports:
//   clk, rst                      clock, async active-low reset
//   req_valid/req_ready           load request handshake (ready iff idle)
//   req_kind/req_addr/req_rd      load flavour, byte address, destination
//   flush                         cancel the in-flight load
//   mem_req_valid/ready, mem_addr word-aligned read request
//   mem_resp_valid/data           read response
//   wb_valid/wb_rd/wb_data        writeback pulse and payload
//   exc_valid/exc_cause/exc_addr  exception pulse and payload
//   busy                          not idle
module load_unit_ctrl
    import load_unit_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  load_kind_t      req_kind,
    input  logic [XLEN-1:0] req_addr,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_valid,
    output logic [3:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr,
    output logic            busy
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_ACC_FAULT = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    load_kind_t      kind_q, kind_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [4:0]      rd_q, rd_d;

    logic            wb_valid_d, exc_valid_d;
    logic [4:0]      wb_rd_d;
    logic [XLEN-1:0] wb_data_d, exc_addr_d;
    logic [3:0]      exc_cause_d;

    logic            illegal_c, misal_c, timeout_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [XLEN-1:0] load_data_c;

    // Status decodes straight off the state register
    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = {addr_q[XLEN-1:2], 2'b00};

    assign timeout_c = (timer_q == TW'(TIMEOUT - 1));

    // Request legality and alignment
    always_comb begin
        illegal_c = 1'b0;
        misal_c   = 1'b0;
        case (req_kind)
            lk_lb, lk_lbu: misal_c = 1'b0;
            lk_lh, lk_lhu: misal_c = req_addr[0];
            lk_lw:         misal_c = |req_addr[1:0];
            default:       illegal_c = 1'b1;
        endcase
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        byte_c = mem_resp_data[{addr_q[1:0], 3'b000} +: 8];
        half_c = mem_resp_data[{addr_q[1], 4'b0000} +: 16];
        case (kind_q)
            lk_lb:   load_data_c = {{(XLEN-8){byte_c[7]}}, byte_c};
            lk_lbu:  load_data_c = {{(XLEN-8){1'b0}}, byte_c};
            lk_lh:   load_data_c = {{(XLEN-16){half_c[15]}}, half_c};
            lk_lhu:  load_data_c = {{(XLEN-16){1'b0}}, half_c};
            default: load_data_c = mem_resp_data;
        endcase
    end

    // Next state and registered pulse outputs
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd;
        wb_data_d   = wb_data;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause;
        exc_addr_d  = exc_addr;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    if (illegal_c || misal_c) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = illegal_c ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        exc_addr_d  = req_addr;
                    end else begin
                        kind_d  = req_kind;
                        addr_d  = req_addr;
                        rd_d    = req_rd;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Once the handshake completes the response is owed, so a
                // flush in that cycle must still drain it.
                if (mem_req_ready) begin
                    timer_d = '0;
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (flush) begin
                    // Flush suppresses any pulse; leave only when nothing is owed
                    state_d = (mem_resp_valid || timeout_c) ? ST_IDLE : ST_DRAIN;
                end else if (mem_resp_valid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_data_c;
                    state_d    = ST_IDLE;
                end else if (timeout_c) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = CAUSE_ACC_FAULT;
                    exc_addr_d  = addr_q;
                    state_d     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                timer_d = timer_q + 1'b1;
                if (mem_resp_valid || timeout_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            kind_q    <= lk_lb;
            addr_q    <= '0;
            rd_q      <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_cause <= '0;
            exc_addr  <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            kind_q    <= kind_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            wb_valid  <= wb_valid_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
            exc_valid <= exc_valid_d;
            exc_cause <= exc_cause_d;
            exc_addr  <= exc_addr_d;
        end
    end

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Self-checking bench for load_unit_ctrl: directed scenarios plus randomized
// loads checked against a transaction-level reference model.
module tb_load_unit_ctrl;
    import load_unit_ctrl_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    load_kind_t  req_kind = lk_lb;
    logic [31:0] req_addr = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] last_wb = '0;

    load_unit_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_addr(req_addr), .req_rd(req_rd), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: cause 0 means the load completes with value val
    function automatic void model(input int kind, input logic [31:0] addr,
                                  input logic [31:0] data, output int cause,
                                  output logic [31:0] val);
        logic [31:0] b, h;
        cause = 0;
        b = (data >> (8 * (addr % 4))) & 32'hFF;
        h = (data >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        val = data;
        if (kind >= 5) cause = 2;
        else if ((kind == 1 || kind == 4) && (addr % 2) != 0) cause = 4;
        else if (kind == 2 && (addr % 4) != 0) cause = 4;
        case (kind)
            0: val = (b >= 128) ? b - 32'd256 : b;
            3: val = b;
            1: val = (h >= 32768) ? h - 32'd65536 : h;
            4: val = h;
            default: val = data;
        endcase
    endfunction

    task automatic accept(input load_kind_t kind, input logic [31:0] addr, input logic [4:0] rd);
        req_valid = 1'b1; req_kind = kind; req_addr = addr; req_rd = rd;
        tick;
        req_valid = 1'b0; req_addr = $urandom;
    endtask

    // One full load; resp_wait >= TO means memory never answers
    task automatic do_load(input load_kind_t kind, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] data, input int req_wait, input int resp_wait);
        int cause;
        int lat;
        logic [31:0] expv;
        model(int'(kind), addr, data, cause, expv);
        mem_resp_valid = 1'($urandom_range(0, 1));
        accept(kind, addr, rd);
        lat = 1;
        mem_resp_valid = 1'b0;
        if (cause != 0) begin
            check("exc_valid", 32'(exc_valid), 1);
            check("exc_cause", 32'(exc_cause), cause);
            check("exc_addr", exc_addr, addr);
            check("wb_hold", wb_data, last_wb);
            check("no_memreq", 32'(mem_req_valid), 0);
            check("ready_exc", 32'(req_ready), 1);
            tick;
            check("exc_pulse_end", 32'(exc_valid), 0);
            check("no_memreq2", 32'(mem_req_valid), 0);
            return;
        end
        check("memreq", 32'(mem_req_valid), 1);
        check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("busy_req", 32'(busy), 1);
        check("ready_req", 32'(req_ready), 0);
        for (int i = 0; i < req_wait; i++) begin
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'($urandom_range(0, 1));
            tick; lat++;
            check("memreq_stall", 32'(mem_req_valid), 1);
            check("mem_addr_stall", mem_addr, addr & 32'hFFFF_FFFC);
            check("ready_stall", 32'(req_ready), 0);
            check("wb_stall", 32'(wb_valid), 0);
        end
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'($urandom_range(0, 1));
        tick; lat++;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        check("memreq_done", 32'(mem_req_valid), 0);
        check("busy_wait", 32'(busy), 1);
        for (int i = 0; i < int'(TO); i++) begin
            if (i == resp_wait) begin
                mem_resp_valid = 1'b1;
                mem_resp_data = data;
            end
            tick; lat++;
            mem_resp_valid = 1'b0;
            mem_resp_data = $urandom;
            if (i == resp_wait) begin
                check("wb_valid", 32'(wb_valid), 1);
                check("wb_data", wb_data, expv);
                check("wb_rd", 32'(wb_rd), 32'(rd));
                check("exc_none", 32'(exc_valid), 0);
                check("busy_done", 32'(busy), 0);
                check("latency", lat, 3 + req_wait + resp_wait);
                last_wb = expv;
                break;
            end else if (i == int'(TO) - 1) begin
                check("to_exc", 32'(exc_valid), 1);
                check("to_cause", 32'(exc_cause), 5);
                check("to_addr", exc_addr, addr);
                check("to_no_wb", 32'(wb_valid), 0);
                check("to_idle", 32'(req_ready), 1);
            end else begin
                check("wait_quiet", 32'(wb_valid | exc_valid), 0);
                check("wait_busy", 32'(busy), 1);
            end
        end
        tick;
        check("pulse_end", 32'(wb_valid | exc_valid), 0);
        check("payload_hold", wb_data, last_wb);
    endtask

    initial begin
        // Reset state
        tick; tick;
        check("rst_wb", 32'(wb_valid), 0);
        check("rst_exc", 32'(exc_valid), 0);
        check("rst_memreq", 32'(mem_req_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_wbdata", wb_data, 0);
        check("rst_excaddr", exc_addr, 0);
        rst = 1'b1;
        tick;

        // Directed loads
        do_load(lk_lb,  32'h0000_1003, 5'd9,  32'h80FF_1234, 0, 0);
        do_load(lk_lh,  32'h0000_2002, 5'd3,  32'h8001_7FFF, 0, 1);
        do_load(lk_lhu, 32'h0000_2002, 5'd4,  32'h8001_7FFF, 1, 0);
        do_load(lk_lbu, 32'h0000_2001, 5'd31, 32'h8001_7FFF, 0, 2);
        do_load(lk_lw,  32'h0000_3001, 5'd1,  32'h1234_5678, 0, 0);
        do_load(lk_invalid, 32'h0000_4000, 5'd1, 32'h0, 0, 0);
        do_load(lk_lw,  32'h0000_5004, 5'd12, 32'hDEAD_BEEF, 5, 0);
        do_load(lk_lw,  32'h0000_6000, 5'd13, 32'h0, 0, TO);
        do_load(lk_lw,  32'h0000_6008, 5'd14, 32'hCAFE_F00D, 0, TO - 1);

        // Flush in WAIT, response arrives while draining
        accept(lk_lw, 32'h0000_0100, 5'd7);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        flush = 1'b1; tick; flush = 1'b0;
        check("drain_ready", 32'(req_ready), 0);
        check("drain_busy", 32'(busy), 1);
        check("drain_quiet", 32'(wb_valid | exc_valid), 0);
        tick;
        check("drain_ready2", 32'(req_ready), 0);
        mem_resp_valid = 1'b1; tick; mem_resp_valid = 1'b0;
        check("drain_done_ready", 32'(req_ready), 1);
        check("drain_done_quiet", 32'(wb_valid | exc_valid), 0);
        tick;
        check("drain_after_quiet", 32'(wb_valid | exc_valid), 0);

        // Flush in WAIT, memory never answers: idle TO cycles after handshake, silently
        accept(lk_lw, 32'h0000_0200, 5'd8);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        flush = 1'b1; tick; flush = 1'b0;
        for (int i = 1; i < int'(TO) - 1; i++) tick;
        check("drain_to_busy", 32'(req_ready), 0);
        tick;
        check("drain_to_idle", 32'(req_ready), 1);
        check("drain_to_quiet", 32'(wb_valid | exc_valid), 0);

        // Flush in REQ with memory stalled
        accept(lk_lb, 32'h0000_0300, 5'd2);
        flush = 1'b1; tick; flush = 1'b0;
        check("flush_req_ready", 32'(req_ready), 1);
        check("flush_req_memreq", 32'(mem_req_valid), 0);
        check("flush_req_quiet", 32'(wb_valid | exc_valid), 0);

        // Flush coinciding with the request handshake
        accept(lk_lb, 32'h0000_0304, 5'd2);
        flush = 1'b1; mem_req_ready = 1'b1; tick; flush = 1'b0; mem_req_ready = 1'b0;
        check("flush_hs_busy", 32'(busy), 1);
        check("flush_hs_memreq", 32'(mem_req_valid), 0);
        mem_resp_valid = 1'b1; tick; mem_resp_valid = 1'b0;
        check("flush_hs_idle", 32'(req_ready), 1);
        check("flush_hs_quiet", 32'(wb_valid | exc_valid), 0);

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        accept(lk_invalid, 32'h0000_0400, 5'd2);
        check("flush_idle_noexc", 32'(exc_valid), 0);
        accept(lk_lw, 32'h0000_0400, 5'd2);
        flush = 1'b0;
        check("flush_idle_nomem", 32'(mem_req_valid), 0);
        check("flush_idle_ready", 32'(req_ready), 1);

        // Randomized loads
        for (int n = 0; n < 60; n++) begin
            do_load(load_kind_t'(3'($urandom_range(0, 5))), $urandom, 5'($urandom),
                    $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, TO)));
        end

        // Reset mid-WAIT
        do_load(lk_lw, 32'h0000_0500, 5'd6, 32'h1111_2222, 0, 0);
        accept(lk_lw, 32'h0000_0600, 5'd6);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(req_ready), 1);
        check("arst_memreq", 32'(mem_req_valid), 0);
        check("arst_wbdata", wb_data, 0);
        check("arst_wbrd", 32'(wb_rd), 0);
        check("arst_exccause", 32'(exc_cause), 0);
        check("arst_memaddr", mem_addr, 0);
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        tick;
        mem_resp_valid = 1'b0;
        check("arst_no_pulse", 32'(wb_valid | exc_valid), 0);
        check("arst_idle", 32'(req_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
